// File: rtl/status_flag_unit.sv
// Condition-flag producer: derives {V,N,Z} from ALU results, holds them in a
// status register, and saves/restores them through a small interrupt LIFO.
module status_flag_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               iClk,
  input  logic                               iRstN,
  input  logic                               iFlagWrEn,
  input  logic                               iSubtract,
  input  logic [DATA_WIDTH-1:0]              iOperandA,
  input  logic [DATA_WIDTH-1:0]              iOperandB,
  input  logic [DATA_WIDTH-1:0]              iResult,
  input  logic                               iFlagLoad,
  input  logic [2:0]                         iFlagData,
  input  logic                               iFlagPush,
  input  logic                               iFlagPop,
  output logic                               oZeroFlag,
  output logic                               oNegativeFlag,
  output logic                               oOverflowFlag,
  output logic                               oFlagHazard,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   oStackDepth,
  output logic                               oStackFull,
  output logic                               oStackEmpty,
  output logic                               oStackErr
);

  localparam int M       = DATA_WIDTH - 1;
  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [2:0]         flags_q, flags_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               err_q, err_d;
  logic [2:0]         stack_q [STACK_DEPTH];
  logic [2:0]         stack_d [STACK_DEPTH];

  logic [2:0]         alu_flags;
  logic               v_add, v_sub;
  logic               full, empty;
  logic               illegal, push_ok, pop_ok, err_event;
  logic [DEPTH_W-1:0] depth_m1;
  logic [IDX_W-1:0]   wr_idx, top_idx;
  logic               unused_operand_bits;

  // Only the sign bits of the operands take part in the overflow rule.
  assign unused_operand_bits = ^{iOperandA, iOperandB};

  assign full     = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign depth_m1 = depth_q - DEPTH_W'(1);
  assign wr_idx   = depth_q[IDX_W-1:0];
  assign top_idx  = depth_m1[IDX_W-1:0];

  always_comb begin
    v_add     = (iOperandA[M] == iOperandB[M]) && (iResult[M] != iOperandA[M]);
    v_sub     = (iOperandA[M] != iOperandB[M]) && (iResult[M] != iOperandA[M]);
    alu_flags = {(iSubtract ? v_sub : v_add), iResult[M], (iResult == '0)};
  end

  always_comb begin
    illegal   = iFlagPush & iFlagPop;
    push_ok   = iFlagPush & ~iFlagPop & ~full;
    pop_ok    = iFlagPop & ~iFlagPush & ~empty;
    err_event = illegal
              | (iFlagPush & ~iFlagPop & full)
              | (iFlagPop & ~iFlagPush & empty);

    flags_d = flags_q;
    depth_d = depth_q;
    err_d   = err_q | err_event;
    stack_d = stack_q;

    // A simultaneous push+pop freezes everything, including load and write.
    if (!illegal) begin
      if (pop_ok) begin
        flags_d = stack_q[top_idx];
        depth_d = depth_m1;
      end else if (iFlagLoad) begin
        flags_d = iFlagData;
      end else if (iFlagWrEn) begin
        flags_d = alu_flags;
      end

      // Push saves the pre-update register value.
      if (push_ok) begin
        stack_d[wr_idx] = flags_q;
        depth_d         = depth_q + DEPTH_W'(1);
      end
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      flags_q <= 3'b000;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  // Stack contents need no reset: depth alone defines which entries are live.
  always_ff @(posedge iClk) begin
    stack_q <= stack_d;
  end

  assign oOverflowFlag = flags_q[2];
  assign oNegativeFlag = flags_q[1];
  assign oZeroFlag     = flags_q[0];
  assign oFlagHazard   = iFlagWrEn | iFlagLoad | iFlagPop;
  assign oStackDepth   = depth_q;
  assign oStackFull    = full;
  assign oStackEmpty   = empty;
  assign oStackErr     = err_q;

endmodule

// File: doc/status_flag_unit.md
# status_flag_unit

Condition-flag producer for the processor datapath. Derives Zero, Negative and Overflow from each ALU result and holds them in a status register. Its registered outputs feed the branch-decision logic's `iZeroFlag`, `iNegativeFlag` and `iOverflowFlag` inputs. A small LIFO saves the flags on interrupt entry and restores them on return, and a hazard output lets decode hold a branch until the flags it depends on are committed.

## Interface
- `DATA_WIDTH`, default 16: ALU operand/result width.
- `STACK_DEPTH`, default 4: number of saved flag sets (≥1).
- `iClk` input 1: rising-edge clock.
- `iRstN` input 1: asynchronous, active-low reset. One clock domain.
- `iFlagWrEn` input 1: capture flags computed from the ALU result this cycle.
- `iSubtract` input 1: 1 means the ALU op was A−B, 0 means A+B (overflow rule select).
- `iOperandA` input DATA_WIDTH: ALU operand A.
- `iOperandB` input DATA_WIDTH: ALU operand B.
- `iResult` input DATA_WIDTH: ALU result.
- `iFlagLoad` input 1: load flags directly from `iFlagData` (move-to-status).
- `iFlagData` input 3: {V,N,Z}, where [2]=V, [1]=N, [0]=Z.
- `iFlagPush` input 1: save the current flags (interrupt entry).
- `iFlagPop` input 1: restore flags from the stack top (interrupt return).
- `oZeroFlag` output 1: registered Z.
- `oNegativeFlag` output 1: registered N.
- `oOverflowFlag` output 1: registered V.
- `oFlagHazard` output 1: a flag-modifying event is in progress this cycle.
- `oStackDepth` output clog2(STACK_DEPTH+1): number of saved entries.
- `oStackFull` output 1: depth equals STACK_DEPTH.
- `oStackEmpty` output 1: depth equals 0.
- `oStackErr` output 1: sticky error for overflow, underflow or an illegal push+pop.

## Operation
Flag computation is combinational from the ALU inputs. Let m = DATA_WIDTH−1.
- Z = (iResult == 0).
- N = iResult[m].
- V for add = (A[m] == B[m]) & (R[m] != A[m]).
- V for subtract = (A[m] != B[m]) & (R[m] != A[m]).

Status register next value, highest priority first:
1. Legal `iFlagPop` with a non-empty stack: register ← stack top.
2. `iFlagLoad`: register ← `iFlagData`.
3. `iFlagWrEn`: register ← computed {V,N,Z}.
4. Otherwise: hold.

A lower-priority request in the same cycle is dropped silently. It does not set `oStackErr`.

Stack behaviour:
- **Push**, when not full and no pop in the same cycle: write the *current registered* flags (pre-update value) at index depth, then depth+1. A concurrent load or write still updates the register normally.
- **Push when full**: the stack is unchanged and `oStackErr` is set.
- **Pop**, when not empty and no push in the same cycle: the register takes entry depth−1, then depth−1.
- **Pop when empty**: the stack and register are unchanged. Load/write in the same cycle then apply per priority. `oStackErr` is set.
- **Push and pop in the same cycle**: illegal. The stack, depth and register are unchanged, so load and write are also suppressed that cycle. `oStackErr` is set.

Stack status outputs:
- `oStackErr` clears only on reset.
- `oStackFull` and `oStackEmpty` are decoded from the registered depth.

## Timing
- All state updates on the rising edge of `iClk`. New flags are visible on the outputs the cycle after the request (latency 1).
- No same-cycle bypass. A branch issued in the cycle of a flag update sees the old flags.
- `oFlagHazard` = `iFlagWrEn` | `iFlagLoad` | `iFlagPop`. It is combinational and high only in the request cycle. Decode stalls flag-dependent branches while it is high.
- Push/pop status changes (depth, full, empty, err) are visible the cycle after the request.
- Reset (`iRstN` low) takes effect immediately, without waiting for a clock edge, at any point including mid-sequence:
  - Z, N, V = 0; `oStackDepth` = 0; `oStackFull` = 0; `oStackEmpty` = 1; `oStackErr` = 0.
  - Stack contents are don't-care.
  - `oFlagHazard` follows its inputs even during reset.
- Deassertion of reset is treated as synchronous to `iClk` upstream. The first edge after release is a normal operating edge.

## Test plan
1. **Reset:** assert `iRstN`=0 between clock edges → all flags 0, depth 0, empty=1, full=0, err=0 immediately.
2. **Add overflow:** A=0x7FFF, B=0x0001, R=0x8000, sub=0, wr=1 → `oFlagHazard`=1 in that cycle; next cycle V=1, N=1, Z=0.
3. **Subtract zero/overflow:** A=0x1234=B, R=0x0000, sub=1 → Z=1, N=0, V=0. Then A=0x8000, B=0x0001, R=0x7FFF, sub=1 → V=1, N=0, Z=0.
4. **Stack fill and drain:**
   - Load {V,N,Z}=1, 2, 3, 4 and push after each load → depth 4, full=1.
   - A 5th push → err=1, depth stays 4.
   - Four pops → flags 4, 3, 2, 1 in order, empty=1.
   - A 5th pop → flags unchanged.
5. **Priority:**
   - Stack top=3'b101. In the same cycle: pop=1, load=1 (`iFlagData`=3'b010), wr=1 with R=0 → flags=3'b101, depth−1, err=0.
   - Push+pop together → nothing changes, err=1.
6. **Reset mid-sequence:** depth 2, flags 3'b011. Assert `iRstN` low mid-cycle → outputs reset immediately. After release, a pop sets err=1 and leaves flags at 0.
